// File: rtl/medidor_hcsr04.sv
// medidor_hcsr04: HC-SR04 trigger/echo range meter with 3-digit BCD centimetre result.
// Define MEDIDOR_ARREDONDA_EN for nearest-cm rounding; otherwise the result truncates.
module medidor_hcsr04 #(
  parameter int TRIGGER_CICLOS = 500,
  parameter int CICLOS_POR_CM  = 2941,
  parameter int TIMEOUT_CICLOS = 100000,
  parameter int MAX_CM         = 400
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        timeout,
  output logic [3:0]  db_estado
);

  localparam logic [3:0] INICIAL       = 4'd0;
  localparam logic [3:0] PREPARACAO    = 4'd1;
  localparam logic [3:0] ENVIA_TRIGGER = 4'd2;
  localparam logic [3:0] ESPERA_ECHO   = 4'd3;
  localparam logic [3:0] MEDIDA        = 4'd4;
  localparam logic [3:0] ARREDONDA     = 4'd5;
  localparam logic [3:0] FINAL         = 4'd6;

  // One counter serves both the trigger width and the echo wait.
  localparam int CNT_MAX =
    (TIMEOUT_CICLOS > TRIGGER_CICLOS) ? TIMEOUT_CICLOS : TRIGGER_CICLOS;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int SW = (CICLOS_POR_CM > 1) ? $clog2(CICLOS_POR_CM) : 1;

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIGGER_CICLOS - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CICLOS - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(CICLOS_POR_CM - 1);

  localparam logic [11:0] MAX_BCD = {
    4'(MAX_CM / 100),
    4'((MAX_CM / 10) % 10),
    4'(MAX_CM % 10)
  };

`ifdef MEDIDOR_ARREDONDA_EN
  localparam logic [SW-1:0] SUB_HALF = SW'(CICLOS_POR_CM / 2);
`endif

  // Decimal increment of a 3-digit BCD value with carry between digits.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] u;
    logic [3:0] d;
    logic [3:0] c;
    u = v[3:0];
    d = v[7:4];
    c = v[11:8];
    if (u == 4'd9) begin
      u = 4'd0;
      if (d == 4'd9) begin
        d = 4'd0;
        c = (c == 4'd9) ? 4'd0 : c + 4'd1;
      end else begin
        d = d + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {c, d, u};
  endfunction

  logic          echo_s1_q;
  logic          echo_s2_q;
  logic          echo_prev_q;
  logic          echo_s;
  logic          echo_rise;

  logic [3:0]    state_q;
  logic [3:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [SW-1:0] sub_q;
  logic [SW-1:0] sub_d;
  logic [11:0]   bcd_q;
  logic [11:0]   bcd_d;
  logic [11:0]   bcd_next;

  logic          trigger_q;
  logic          trigger_d;
  logic [11:0]   medida_q;
  logic [11:0]   medida_d;
  logic          pronto_q;
  logic          pronto_d;
  logic          timeout_q;
  logic          timeout_d;

  logic          trig_done;
  logic          tmo_hit;
  logic          tmo_event;
  logic          sub_wrap;
  logic          sat_hit;
  logic          round_up;

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_s1_q   <= 1'b0;
      echo_s2_q   <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      echo_s1_q   <= echo;
      echo_s2_q   <= echo_s1_q;
      echo_prev_q <= echo_s2_q;
    end
  end

  assign echo_s    = echo_s2_q;
  assign echo_rise = echo_s & ~echo_prev_q;

  // Shared condition decode used by the FSM and the datapath.
  always_comb begin
    bcd_next  = bcd_inc(bcd_q);
    trig_done = (cnt_q == TRIG_LAST);
    tmo_hit   = (cnt_q == TMO_LAST);
    sub_wrap  = (sub_q == SUB_LAST);
    tmo_event = (state_q == ESPERA_ECHO) & ~echo_rise & tmo_hit;
    sat_hit   = (state_q == MEDIDA) & echo_s & sub_wrap &
                (bcd_next == MAX_BCD);
`ifdef MEDIDOR_ARREDONDA_EN
    round_up  = (sub_q >= SUB_HALF) && (bcd_q != MAX_BCD);
`else
    round_up  = 1'b0;
`endif
  end

  // Next-state logic; undefined codes fall back to INICIAL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL: begin
        if (medir) state_d = PREPARACAO;
      end
      PREPARACAO: begin
        state_d = ENVIA_TRIGGER;
      end
      ENVIA_TRIGGER: begin
        if (trig_done) state_d = ESPERA_ECHO;
      end
      ESPERA_ECHO: begin
        if (echo_rise) state_d = MEDIDA;
        else if (tmo_hit) state_d = FINAL;
      end
      MEDIDA: begin
        if (!echo_s) state_d = ARREDONDA;
        else if (sat_hit) state_d = FINAL;
      end
      ARREDONDA: begin
        state_d = FINAL;
      end
      FINAL: begin
        state_d = INICIAL;
      end
      default: begin
        state_d = INICIAL;
      end
    endcase
  end

  // Cycle counter: trigger width, then echo-wait timeout.
  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      PREPARACAO: begin
        cnt_d = '0;
      end
      ENVIA_TRIGGER: begin
        cnt_d = trig_done ? '0 : cnt_q + CW'(1);
      end
      ESPERA_ECHO: begin
        cnt_d = echo_rise ? '0 : cnt_q + CW'(1);
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Echo width: sub-centimetre counter feeding the BCD centimetre count.
  // The edge-detect cycle already has echo_s high, so it counts as the first.
  always_comb begin
    sub_d = sub_q;
    bcd_d = bcd_q;
    case (state_q)
      PREPARACAO: begin
        sub_d = '0;
        bcd_d = '0;
      end
      ESPERA_ECHO: begin
        if (echo_rise) sub_d = SW'(1);
      end
      MEDIDA: begin
        if (echo_s) begin
          if (sub_wrap) begin
            sub_d = '0;
            bcd_d = bcd_next;
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end
      end
      ARREDONDA: begin
        if (round_up) bcd_d = bcd_next;
      end
      default: begin
        sub_d = sub_q;
      end
    endcase
  end

  // Result registers: held across measurements, timeout cleared on start.
  always_comb begin
    timeout_d = timeout_q;
    medida_d  = medida_q;
    case (state_q)
      PREPARACAO: begin
        timeout_d = 1'b0;
      end
      ESPERA_ECHO: begin
        if (tmo_event) begin
          timeout_d = 1'b1;
          medida_d  = 12'h000;
        end
      end
      MEDIDA: begin
        if (sat_hit) begin
          timeout_d = 1'b1;
          medida_d  = MAX_BCD;
        end
      end
      ARREDONDA: begin
        medida_d = round_up ? bcd_next : bcd_q;
      end
      default: begin
        medida_d = medida_q;
      end
    endcase
  end

  // Moore strobes registered from the upcoming state.
  always_comb begin
    trigger_d = (state_d == ENVIA_TRIGGER);
    pronto_d  = (state_d == FINAL);
  end

  // FSM and counter state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INICIAL;
      cnt_q   <= '0;
      sub_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      bcd_q   <= bcd_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trigger_q <= 1'b0;
      medida_q  <= 12'h000;
      pronto_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      trigger_q <= trigger_d;
      medida_q  <= medida_d;
      pronto_q  <= pronto_d;
      timeout_q <= timeout_d;
    end
  end

  assign trigger   = trigger_q;
  assign medida    = medida_q;
  assign pronto    = pronto_q;
  assign timeout   = timeout_q;
  assign db_estado = state_q;

endmodule
